// File: rtl/branch_predict_unit_pkg.sv
// Shared opcode, funct and BTB counter definitions for the branch predict unit.
package branch_predict_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_e;

    function automatic cnt_e cnt_next(cnt_e c, logic taken);
        cnt_e n;
        n = c;
        unique case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_predict_unit_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports, one sync write port.
module btb_table
    import branch_predict_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  ra_idx_i,
    output logic              ra_valid_o,
    output logic [TAG_W-1:0]  ra_tag_o,
    output cnt_e              ra_cnt_o,
    output logic [DATA_W-1:0] ra_tgt_o,
    input  logic [IDX_W-1:0]  rb_idx_i,
    output logic              rb_valid_o,
    output logic [TAG_W-1:0]  rb_tag_o,
    output cnt_e              rb_cnt_o,
    output logic [DATA_W-1:0] rb_tgt_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  cnt_e              wr_cnt_i,
    input  logic [DATA_W-1:0] wr_tgt_i
);

    logic              valid_q [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    cnt_e              cnt_q   [DEPTH];
    logic [DATA_W-1:0] tgt_q   [DEPTH];

    assign ra_valid_o = valid_q[ra_idx_i];
    assign ra_tag_o   = tag_q[ra_idx_i];
    assign ra_cnt_o   = cnt_q[ra_idx_i];
    assign ra_tgt_o   = tgt_q[ra_idx_i];

    assign rb_valid_o = valid_q[rb_idx_i];
    assign rb_tag_o   = tag_q[rb_idx_i];
    assign rb_cnt_o   = cnt_q[rb_idx_i];
    assign rb_tgt_o   = tgt_q[rb_idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                cnt_q[i]   <= WNT;
                tgt_q[i]   <= '0;
            end
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            tag_q[wr_idx_i]   <= wr_tag_i;
            cnt_q[wr_idx_i]   <= wr_cnt_i;
            tgt_q[wr_idx_i]   <= wr_tgt_i;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolver with BTB prediction, mispredict redirect and link writeback.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BTB_DEPTH = 16,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_fetch_pc,
    output logic              o_pred_taken,
    output logic [DATA_W-1:0] o_pred_target,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic [5:0]        i_op,
    input  logic [DATA_W-1:0] i_sign_ext,
    input  logic [25:0]       i_jump_address,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_rs_reg,
    input  logic [DATA_W-1:0] i_rt_reg,
    input  logic [4:0]        i_rd_address,
    input  logic              i_pred_taken,
    input  logic [DATA_W-1:0] i_pred_target,
    output logic              o_mispredict,
    output logic [DATA_W-1:0] o_redirect_pc,
    output logic              os_write_jump,
    output logic [4:0]        o_reg_jump_address,
    output logic [DATA_W-1:0] o_link_value,
    output logic [CNT_W-1:0]  o_mispredict_count
);

    localparam int IDX_W = $clog2(BTB_DEPTH);

    logic [IDX_W-1:0]  f_idx, r_idx;
    logic [TAG_W-1:0]  f_tag, r_tag;
    logic              f_valid, r_valid;
    logic [TAG_W-1:0]  f_etag, r_etag;
    cnt_e              f_cnt, r_cnt;
    logic [DATA_W-1:0] f_tgt, r_tgt;
    logic              f_hit, r_hit;

    assign f_idx = i_fetch_pc[IDX_W+1:2];
    assign f_tag = i_fetch_pc[TAG_W+IDX_W+1:IDX_W+2];
    assign r_idx = i_pc[IDX_W+1:2];
    assign r_tag = i_pc[TAG_W+IDX_W+1:IDX_W+2];

    logic              we;
    cnt_e              wr_cnt;
    logic [DATA_W-1:0] wr_tgt;

    btb_table #(
        .DATA_W (DATA_W),
        .DEPTH  (BTB_DEPTH),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .ra_idx_i   (f_idx),
        .ra_valid_o (f_valid),
        .ra_tag_o   (f_etag),
        .ra_cnt_o   (f_cnt),
        .ra_tgt_o   (f_tgt),
        .rb_idx_i   (r_idx),
        .rb_valid_o (r_valid),
        .rb_tag_o   (r_etag),
        .rb_cnt_o   (r_cnt),
        .rb_tgt_o   (r_tgt),
        .we_i       (we),
        .wr_idx_i   (r_idx),
        .wr_tag_i   (r_tag),
        .wr_cnt_i   (wr_cnt),
        .wr_tgt_i   (wr_tgt)
    );

    assign f_hit = f_valid & (f_etag == f_tag);
    assign r_hit = r_valid & (r_etag == r_tag);

    assign o_pred_taken  = f_hit & f_cnt[1];
    assign o_pred_target = f_hit ? f_tgt : '0;

    logic              is_beq, is_bne, is_jmp, is_jal;
    logic              is_jreg, is_jalr, is_cond, is_ctrl;
    logic              taken;
    logic [DATA_W-1:0] pc_plus4, target, next_pc;

    assign pc_plus4 = i_pc + DATA_W'(4);
    assign is_beq   = (i_op == OP_BEQ);
    assign is_bne   = (i_op == OP_BNE);
    assign is_jal   = (i_op == OP_JAL);
    assign is_jmp   = (i_op == OP_J) | is_jal;
    assign is_jalr  = (i_op == OP_SPECIAL) & (i_sign_ext[5:0] == FN_JALR);
    assign is_jreg  = ((i_op == OP_SPECIAL) & (i_sign_ext[5:0] == FN_JR))
                    | is_jalr;
    assign is_cond  = is_beq | is_bne;
    assign is_ctrl  = is_cond | is_jmp | is_jreg;

    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
        unique case (1'b1)
            is_beq: begin
                taken  = (i_rs_reg == i_rt_reg);
                target = pc_plus4 + (i_sign_ext << 2);
            end
            is_bne: begin
                taken  = (i_rs_reg != i_rt_reg);
                target = pc_plus4 + (i_sign_ext << 2);
            end
            is_jmp: begin
                taken  = 1'b1;
                target = {pc_plus4[DATA_W-1:28], i_jump_address, 2'b00};
            end
            is_jreg: begin
                taken  = 1'b1;
                target = i_rs_reg;
            end
            default: begin
                taken  = 1'b0;
                target = pc_plus4;
            end
        endcase
    end

    assign next_pc = taken ? target : pc_plus4;

    logic resolve, mis;
    assign resolve = i_valid & ~i_stall;

    // A predicted-taken non-control instruction is a BTB alias.
    always_comb begin
        mis = 1'b0;
        if (is_ctrl)
            mis = (taken != i_pred_taken)
                | (taken & i_pred_taken & (target != i_pred_target));
        else
            mis = i_pred_taken;
    end

    always_comb begin
        we     = 1'b0;
        wr_cnt = r_cnt;
        wr_tgt = r_tgt;
        if (resolve && is_ctrl) begin
            if (r_hit && is_cond) begin
                we     = 1'b1;
                wr_cnt = cnt_next(r_cnt, taken);
                wr_tgt = taken ? target : r_tgt;
            end else if (r_hit) begin
                we     = 1'b1;
                wr_cnt = ST;
                wr_tgt = target;
            end else if (taken) begin
                we     = 1'b1;
                wr_cnt = is_cond ? WT : ST;
                wr_tgt = target;
            end
        end
    end

    logic              mis_d, mis_q;
    logic [DATA_W-1:0] redir_d, redir_q;
    logic              wj_d, wj_q;
    logic [4:0]        lrd_d, lrd_q;
    logic [DATA_W-1:0] link_d, link_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    always_comb begin
        mis_d   = resolve & mis;
        redir_d = resolve ? next_pc : '0;
        wj_d    = resolve & (is_jal | is_jalr);
        lrd_d   = '0;
        link_d  = '0;
        if (wj_d) begin
            lrd_d  = is_jal ? LINK_REG : i_rd_address;
            link_d = i_pc + DATA_W'(8);
        end
        cnt_d = cnt_q;
        if (mis_d && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q   <= 1'b0;
            redir_q <= '0;
            wj_q    <= 1'b0;
            lrd_q   <= '0;
            link_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mis_q   <= mis_d;
            redir_q <= redir_d;
            wj_q    <= wj_d;
            lrd_q   <= lrd_d;
            link_q  <= link_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_mispredict       = mis_q;
    assign o_redirect_pc      = redir_q;
    assign os_write_jump      = wj_q;
    assign o_reg_jump_address = lrd_q;
    assign o_link_value       = link_q;
    assign o_mispredict_count = cnt_q;

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the ID-stage branch resolver, adding a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- The fetch side reads the BTB combinationally to predict taken/target for the IF-stage PC.
- The resolve side decodes BEQ/BNE/J/JAL/JR/JALR, computes the actual outcome and target, and flags mispredicts with a redirect PC.
- It drives link-register writeback, updates the BTB and counts mispredicts.

Parameters:
DATA_W, 32, register/PC width
BTB_DEPTH, 16, BTB entries; power of two, >=2; IDX_W = log2(BTB_DEPTH)
TAG_W, 8, tag bits taken from PC[TAG_W+IDX_W+1 : IDX_W+2]
CNT_W, 16, width of the mispredict statistics counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_fetch_pc  in  DATA_W  IF-stage PC for lookup
o_pred_taken  out  1  BTB prediction (combinational)
o_pred_target  out  DATA_W  predicted target (combinational)
i_valid  in  1  resolve-stage instruction valid
i_stall  in  1  pipeline stall; freezes resolve and update
i_op  in  6  opcode
i_sign_ext  in  DATA_W  sign-extended immediate; [5:0] is funct for SPECIAL
i_jump_address  in  26  J-type index
i_pc  in  DATA_W  PC of the resolving instruction
i_rs_reg  in  DATA_W  rs value (forwarded)
i_rt_reg  in  DATA_W  rt value (forwarded)
i_rd_address  in  5  rd field
i_pred_taken  in  1  prediction carried with the instruction
i_pred_target  in  DATA_W  predicted target carried with the instruction
o_mispredict  out  1  registered; redirect fetch
o_redirect_pc  out  DATA_W  registered correct next PC
os_write_jump  out  1  registered link write enable
o_reg_jump_address  out  5  registered link destination
o_link_value  out  DATA_W  registered return address
o_mispredict_count  out  CNT_W  saturating mispredict count

Behaviour:
- Decode:
  - BEQ 000100: taken iff rs==rt.
  - BNE 000101: taken iff rs!=rt.
  - J 000010, JAL 000011: always taken.
  - SPECIAL 000000 with funct 001000 (JR) or 001001 (JALR): always taken.
  - Anything else: non-control.
- Targets:
  - Branch: i_pc+4+(i_sign_ext<<2), modulo 2^DATA_W.
  - J/JAL: {(i_pc+4)[DATA_W-1:28], i_jump_address, 2'b00}.
  - JR/JALR: i_rs_reg.
  - Fall-through: i_pc+4.
- Link: JAL writes r31 and JALR writes rd, both with value i_pc+8. No link write for other instructions.
- Mispredict (resolve when i_valid & !i_stall):
  - actual_taken != i_pred_taken, or both taken with target != i_pred_target.
  - A non-control instruction with i_pred_taken=1 (alias) mispredicts and redirects to i_pc+4.
- Latency: all resolve outputs are registered, valid the cycle after the resolve edge, and held for exactly one cycle (o_mispredict/os_write_jump pulse). While i_stall=1, outputs deassert to 0 and no state changes.
- Lookup:
  - idx = PC[IDX_W+1:2]; hit = valid[idx] & tag[idx]==tag(PC).
  - o_pred_taken = hit & cnt[idx][1]; o_pred_target = target[idx] on hit, else 0.
- Update (resolve edge, control instructions only):
  - Hit, conditional branch: counter +1 if taken (saturate at 3), else -1 (saturate at 0); target rewritten if taken.
  - Hit, unconditional: counter=3, target rewritten.
  - Miss and taken: allocate (overwrite): valid=1, tag, target, counter=2 for conditional, 3 for unconditional.
  - Miss and not taken: no allocation.
  - Non-control alias entries are left untouched.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no bypass).
- o_mispredict_count increments on each registered mispredict and saturates at all-ones.
- Reset: all valid=0, counters=1, tags/targets=0; all registered outputs and the count are 0. Reset wins over a concurrent valid resolve.

Decomposition:
- Shared package: opcode/funct constants (OP_SPECIAL, OP_BEQ, OP_BNE, OP_J, OP_JAL, FN_JR, FN_JALR), LINK_REG=31, counter encodings (SNT=0, WNT=1, WT=2, ST=3).
- Sub-module btb_table: the storage arrays, combinational read port and sync write port.

Test Plan (BTB_DEPTH=16, TAG_W=8):
1. After reset, BEQ pc=0x40, rs=rt=5, sign_ext=3, pred_taken=0 -> next cycle o_mispredict=1, redirect 0x50, count=1; then i_fetch_pc=0x40 -> o_pred_taken=1, target 0x50.
2. BNE pc=0x40, rs=rt=7, pred_taken=1/target 0x50 -> mispredict, redirect 0x44; counter 2->1; lookup 0x40 -> o_pred_taken=0.
3. JAL pc=0x100, jump_address=0x50, pred_taken=0 -> redirect 0x140, os_write_jump=1, reg 31, link 0x108; second JAL predicted 0x140 -> no mispredict.
4. JALR pc=0x200, rs=0x300, rd=2, pred_taken=1/target 0x300 -> o_mispredict=0, link write rd=2 value 0x208; pred_target 0x304 -> mispredict, redirect 0x300.
5. Alias: train 0x40, then taken BEQ pc=0x440 (same idx, tag 0x11) -> lookup 0x40 misses (pred 0), lookup 0x440 hits.
6. i_stall=1 during valid BEQ -> no outputs, no update; assert rst with a resolve -> outputs 0, BTB cleared, count 0.
